// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit serializer fed by a registered-read sync FIFO.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// then STOP_BITS stop bits. Each bit lasts baud_div+1 clocks.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
module uart_tx_engine #(
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_enable,
   input  logic [15:0]          baud_div,
   input  logic                 parity_odd,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [DATA_BITS-1:0] fifo_rd_data,
   output logic                 txd,
   output logic                 busy,
   output logic                 frame_done
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic [15:0]           baud_q, baud_d;
   logic [15:0]           baud_cnt_q, baud_cnt_d;
   logic [3:0]            bit_cnt_q, bit_cnt_d;
   logic                  par_q, par_d;
   logic                  txd_q, txd_d;
   logic                  rd_en_q, rd_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  bit_end_s;
   logic                  in_bit_s;

`ifdef UART_TX_PARITY_EN
   // Parity over the data word, inverted for odd parity.
   function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                        input logic odd);
      return (^data) ^ odd;
   endfunction
`else
   logic unused_parity_s;
   assign unused_parity_s = parity_odd;
`endif

   assign bit_end_s = (baud_cnt_q == baud_q);
   assign in_bit_s  = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PARITY) || (state_q == ST_STOP);

   // State register, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         baud_q     <= 16'd0;
         baud_cnt_q <= 16'd0;
         bit_cnt_q  <= 4'd0;
         par_q      <= 1'b0;
         txd_q      <= 1'b1;
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         baud_q     <= baud_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         par_q      <= par_d;
         txd_q      <= txd_d;
         rd_en_q    <= rd_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Bit-period counter: counts 0..baud_q inside bit states, held at 0 elsewhere.
   always_comb begin
      baud_cnt_d = 16'd0;
      if (in_bit_s) begin
         if (bit_end_s) begin
            baud_cnt_d = 16'd0;
         end else begin
            baud_cnt_d = baud_cnt_q + 16'd1;
         end
      end else begin
         baud_cnt_d = 16'd0;
      end
   end

   // Next-state logic, shift register, latched frame settings and bit counter.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      baud_d    = baud_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      case (state_q)
         ST_IDLE: begin
            if (tx_enable && !fifo_empty) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            shift_d   = fifo_rd_data;
            baud_d    = baud_div;
            bit_cnt_d = 4'd0;
`ifdef UART_TX_PARITY_EN
            par_d     = calc_parity(fifo_rd_data, parity_odd);
`else
            par_d     = 1'b0;
`endif
            state_d   = ST_START;
         end
         ST_START: begin
            if (bit_end_s) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                  bit_cnt_d = 4'd0;
`ifdef UART_TX_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end_s) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end_s) begin
               if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                  bit_cnt_d = 4'd0;
                  state_d   = ST_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every output leaves a flop.
   always_comb begin
      txd_d = 1'b1;
      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: txd_d = par_d;
`endif
         default:   txd_d = 1'b1;
      endcase
      rd_en_d = (state_d == ST_FETCH);
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_q == ST_STOP) && (state_d == ST_IDLE);
   end

   assign txd        = txd_q;
   assign fifo_rd_en = rd_en_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine with a FIFO model and a frame-level
// reference model (bit list expanded by the bit period).
module tb_uart_tx_engine;

   localparam int DB = 8;
   localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic          clk;
   logic          reset;
   logic          tx_enable;
   logic [15:0]   baud_div;
   logic          parity_odd;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DB-1:0] fifo_rd_data;
   logic          txd;
   logic          busy;
   logic          frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] mem [0:255];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int pops = 0;
   int underflows = 0;
   int done_cnt = 0;

   uart_tx_engine #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
      .clk(clk), .reset(reset), .tx_enable(tx_enable), .baud_div(baud_div),
      .parity_odd(parity_odd), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .txd(txd), .busy(busy), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   // FIFO model: registered read, data valid the cycle after the pop.
   always @(posedge clk) begin
      if (fifo_rd_en === 1'b1 && !fifo_empty) begin
         fifo_rd_data <= mem[rd_ptr % 256];
         rd_ptr <= rd_ptr + 1;
         pops <= pops + 1;
      end
      if (fifo_rd_en === 1'b1 && fifo_empty) underflows <= underflows + 1;
      if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [7:0] d);
      mem[wr_ptr % 256] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   // Called at a negedge in the cycle where DUT is IDLE with enable and data.
   // Walks FETCH, LOAD, every bit cycle and the frame_done cycle.
   task automatic expect_frame(input logic [7:0] data, input logic podd,
                               input int baud, input bit scramble,
                               input int drop_bit, input string name);
      logic bits[$];
      logic [3:0] obs, exp;
      int cyc;
      bits = {};
      bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) bits.push_back(data[i]);
      if (PB == 1) bits.push_back((^data) ^ podd);
      for (int i = 0; i < SB; i++) bits.push_back(1'b1);
      cyc = 0;
      // FETCH then LOAD: mark level, busy, pop only in FETCH
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         obs = {txd, busy, fifo_rd_en, frame_done};
         exp = (k == 0) ? 4'b1110 : 4'b1100;
         n_cmp++;
         if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s pre cyc %0d: got %b want %b", name, cyc, obs, exp);
         end
         cyc++;
      end
      for (int b = 0; b < bits.size(); b++) begin
         for (int k = 0; k <= baud; k++) begin
            @(negedge clk);
            obs = {txd, busy, fifo_rd_en, frame_done};
            exp = {bits[b], 1'b1, 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
               n_bad++;
               $display("FAIL %s bit %0d cyc %0d: got %b want %b", name, b, cyc, obs, exp);
            end
            if (scramble && b == 0 && k == 0) begin
               baud_div = 16'($urandom_range(0, 7));
               parity_odd = 1'($urandom_range(0, 1));
            end
            if (b == drop_bit && k == 0) tx_enable = 1'b0;
            cyc++;
         end
      end
      @(negedge clk);
      obs = {txd, busy, fifo_rd_en, frame_done};
      n_cmp++;
      if (obs !== 4'b1001) begin
         n_bad++;
         $display("FAIL %s done cyc %0d: got %b want 1001", name, cyc, obs);
      end
   endtask

   task automatic check_idle(input int n, input string name);
      logic [3:0] obs;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         obs = {txd, busy, fifo_rd_en, frame_done};
         n_cmp++;
         if (obs !== 4'b1000) begin
            n_bad++;
            $display("FAIL %s idle cyc %0d: got %b want 1000", name, i, obs);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; tx_enable = 1'b0; baud_div = 16'd0; parity_odd = 1'b0;
      repeat (2) @(negedge clk);
      check_idle(3, "reset_hold");
      reset = 1'b0;
      check_idle(3, "reset_release");
   endtask

   task automatic test_single();
      int p0, d0;
      p0 = pops; d0 = done_cnt;
      baud_div = 16'd3; parity_odd = 1'b0; tx_enable = 1'b1;
      push(8'hA5);
      expect_frame(8'hA5, 1'b0, 3, 1'b0, -1, "single");
      check_idle(2, "single_after");
      n_cmp++;
      if (pops - p0 != 1 || done_cnt - d0 != 1) begin
         n_bad++;
         $display("FAIL single_counts: pops %0d done %0d want 1 1", pops - p0, done_cnt - d0);
      end
   endtask

   task automatic test_empty();
      int p0;
      p0 = pops;
      tx_enable = 1'b1;
      check_idle(100, "empty");
      n_cmp++;
      if (pops != p0) begin
         n_bad++;
         $display("FAIL empty_pops: got %0d want %0d", pops, p0);
      end
   endtask

   task automatic test_back_to_back();
      int p0;
      p0 = pops;
      baud_div = 16'd0; tx_enable = 1'b1;
      push(8'h00); push(8'hFF);
      expect_frame(8'h00, parity_odd, 0, 1'b0, -1, "b2b_first");
      expect_frame(8'hFF, parity_odd, 0, 1'b0, -1, "b2b_second");
      n_cmp++;
      if (pops - p0 != 2) begin
         n_bad++;
         $display("FAIL b2b_pops: got %0d want 2", pops - p0);
      end
   endtask

   task automatic test_enable_drop();
      int p0;
      p0 = pops;
      baud_div = 16'd2; tx_enable = 1'b1;
      push(8'h5A); push(8'hC3); push(8'h0F);
      // index 3 of the bit list is DATA bit 2
      expect_frame(8'h5A, parity_odd, 2, 1'b0, 3, "drop");
      check_idle(20, "drop_after");
      n_cmp++;
      if (pops - p0 != 1 || wr_ptr - rd_ptr != 2) begin
         n_bad++;
         $display("FAIL drop_fifo: pops %0d left %0d want 1 2", pops - p0, wr_ptr - rd_ptr);
      end
      wr_ptr = rd_ptr;
   endtask

   task automatic test_reset_mid();
      int d0, p0;
      logic [3:0] obs;
      baud_div = 16'd2; tx_enable = 1'b1;
      push(8'h3C);
      // FETCH, LOAD, start bit and DATA bits 0..3, then first cycle of bit 4
      repeat (2 + 5 * 3 + 1) @(negedge clk);
      n_cmp++;
      if (txd !== 1'b1 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL rstmid_bit4: txd %b busy %b want 1 1", txd, busy);
      end
      d0 = done_cnt; p0 = pops;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      obs = {txd, busy, fifo_rd_en, frame_done};
      n_cmp++;
      if (obs !== 4'b1000) begin
         n_bad++;
         $display("FAIL rstmid_after: got %b want 1000", obs);
      end
      check_idle(10, "rstmid_idle");
      n_cmp++;
      if (done_cnt != d0 || pops != p0) begin
         n_bad++;
         $display("FAIL rstmid_counts: done %0d pops %0d want %0d %0d", done_cnt, pops, d0, p0);
      end
      push(8'h96);
      expect_frame(8'h96, parity_odd, 2, 1'b0, -1, "rstmid_new");
   endtask

   task automatic test_parity();
      tx_enable = 1'b1;
      for (int po = 0; po < 2; po++) begin
         baud_div = 16'd1; parity_odd = 1'(po);
         push(8'hA5);
         expect_frame(8'hA5, 1'(po), 1, 1'b0, -1, po ? "parity_odd" : "parity_even");
      end
   endtask

   task automatic test_random();
      logic [7:0] w [2];
      int bd;
      logic po;
      tx_enable = 1'b1;
      for (int it = 0; it < 12; it++) begin
         w[0] = 8'($urandom); w[1] = 8'($urandom);
         push(w[0]); push(w[1]);
         for (int j = 0; j < 2; j++) begin
            bd = $urandom_range(0, 4);
            po = 1'($urandom_range(0, 1));
            baud_div = 16'(bd); parity_odd = po;
            expect_frame(w[j], po, bd, 1'b1, -1, "random");
         end
      end
      check_idle(3, "random_after");
   endtask

   initial begin
      reset = 1'b1; tx_enable = 1'b0; baud_div = 16'd0; parity_odd = 1'b0;
      test_reset();
      test_single();
      test_empty();
      test_back_to_back();
      test_enable_drop();
      tx_enable = 1'b1;
      test_reset_mid();
      test_parity();
      test_random();
      n_cmp++;
      if (underflows != 0) begin
         n_bad++;
         $display("FAIL underflow: got %0d pops on empty want 0", underflows);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
